// File: rtl/shared_gate_arbiter.sv
// shared_gate_arbiter: round-robin single-owner arbiter with hold limit and a forced gap cycle between owners
//   clk, rst_n        : clock, async active-low reset
//   req[N_REQ]        : request levels
//   done              : owner completion pulse
//   gnt, gnt_vld      : registered one-hot grant and its valid
//   gnt_id            : granted index (0 when idle)
//   busy              : in GRANT or GAP
//   timeout,timeout_id: forced-release pulse and last forced-release index
module shared_gate_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_vld,
  output logic [ID_W-1:0]  gnt_id,
  output logic             busy,
  output logic             timeout,
  output logic [ID_W-1:0]  timeout_id
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t state, state_n;
  logic [N_REQ-1:0] gnt_n;
  logic [ID_W-1:0] gnt_id_n, ptr, ptr_n, win, timeout_id_n;
  logic [7:0] hold, hold_n;
  logic [ID_W:0] j;
  logic win_vld, timeout_n, at_max, rel, forced;
  // Scan from the highest offset down so the lowest offset from ptr wins last.
  always_comb begin
    win = '0;
    win_vld = 1'b0;
    j = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = {1'b0, ptr} + (ID_W+1)'(k);
      j = (j >= (ID_W+1)'(N_REQ)) ? j - (ID_W+1)'(N_REQ) : j;
      if (req[j[ID_W-1:0]]) begin
        win = j[ID_W-1:0];
        win_vld = 1'b1;
      end
    end
  end
  assign at_max = hold == 8'(MAX_HOLD);
  assign rel = done | ~req[gnt_id] | at_max;
  assign forced = at_max & ~done & req[gnt_id];
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    gnt_id_n = gnt_id;
    hold_n = hold;
    ptr_n = ptr;
    timeout_n = 1'b0;
    timeout_id_n = timeout_id;
    if (state == GRANT) begin
      if (rel) begin
        state_n = GAP;
        gnt_n = '0;
        gnt_id_n = '0;
        hold_n = '0;
        timeout_n = forced;
        timeout_id_n = forced ? gnt_id : timeout_id;
      end else begin
        hold_n = hold + 8'd1;
      end
    end else if (win_vld) begin
      state_n = GRANT;
      gnt_n = N_REQ'(1) << win;
      gnt_id_n = win;
      hold_n = 8'd1;
      ptr_n = (win == ID_W'(N_REQ - 1)) ? '0 : win + ID_W'(1);
    end else begin
      state_n = IDLE;
      gnt_n = '0;
      gnt_id_n = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt <= '0;
      gnt_id <= '0;
      hold <= '0;
      ptr <= '0;
      timeout <= 1'b0;
      timeout_id <= '0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      gnt_id <= gnt_id_n;
      hold <= hold_n;
      ptr <= ptr_n;
      timeout <= timeout_n;
      timeout_id <= timeout_id_n;
    end
  end
  assign gnt_vld = |gnt;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_shared_gate_arbiter.sv
// tb_shared_gate_arbiter: directed self-checking bench for shared_gate_arbiter
module tb_shared_gate_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = '0;
  logic done = 1'b0;
  logic [3:0] gnt;
  logic gnt_vld;
  logic [1:0] gnt_id;
  logic busy;
  logic timeout;
  logic [1:0] timeout_id;
  int total = 0;
  int bad = 0;
  int cnt;
  shared_gate_arbiter #(.N_REQ(4), .ID_W(2), .MAX_HOLD(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done), .gnt(gnt), .gnt_vld(gnt_vld),
    .gnt_id(gnt_id), .busy(busy), .timeout(timeout), .timeout_id(timeout_id)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    done = 1'b0;
    step();
    rst_n = 1'b1;
  endtask
  initial begin
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_vld", 32'(gnt_vld), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_to", 32'(timeout), 0);
    step();
    rst_n = 1'b1;
    step();
    req = 4'b0001;
    step();
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_id", 32'(gnt_id), 0);
    chk("t1_vld", 32'(gnt_vld), 1);
    chk("t1_busy", 32'(busy), 1);
    step();
    step();
    chk("t1_hold", 32'(gnt), 32'h1);
    done = 1'b1;
    step();
    done = 1'b0;
    req = '0;
    chk("t1_gap_gnt", 32'(gnt), 0);
    chk("t1_gap_busy", 32'(busy), 1);
    step();
    chk("t1_idle_busy", 32'(busy), 0);
    chk("t1_idle_gnt", 32'(gnt), 0);
    do_reset();
    req = 4'b1111;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t2_gnt", 32'(gnt), 32'h1 << (i % 4));
      chk("t2_id", 32'(gnt_id), 32'(i % 4));
      step();
      chk("t2_hold", 32'(gnt), 32'h1 << (i % 4));
      done = 1'b1;
      step();
      done = 1'b0;
      chk("t2_gap", 32'(gnt), 0);
      chk("t2_gap_busy", 32'(busy), 1);
      step();
    end
    do_reset();
    req = 4'b0100;
    step();
    cnt = 0;
    while (gnt != 0 && cnt < 40) begin
      cnt++;
      step();
    end
    chk("t3_len", 32'(cnt), 16);
    chk("t3_to", 32'(timeout), 1);
    chk("t3_to_id", 32'(timeout_id), 2);
    chk("t3_gap_gnt", 32'(gnt), 0);
    step();
    chk("t3_regnt", 32'(gnt), 32'h4);
    chk("t3_to_clr", 32'(timeout), 0);
    chk("t3_to_id_hold", 32'(timeout_id), 2);
    for (int i = 0; i < 15; i++) step();
    chk("t4_last", 32'(gnt), 32'h4);
    done = 1'b1;
    step();
    done = 1'b0;
    req = '0;
    chk("t4_rel", 32'(gnt), 0);
    chk("t4_no_to", 32'(timeout), 0);
    chk("t4_to_id", 32'(timeout_id), 2);
    step();
    do_reset();
    req = 4'b0010;
    step();
    chk("t5_pre", 32'(gnt), 32'h2);
    done = 1'b1;
    step();
    done = 1'b0;
    req = '0;
    step();
    req = 4'b1010;
    step();
    chk("t5_gnt3", 32'(gnt), 32'h8);
    chk("t5_id3", 32'(gnt_id), 3);
    step();
    req = 4'b0010;
    step();
    chk("t5_drop", 32'(gnt), 0);
    step();
    chk("t5_gnt1", 32'(gnt), 32'h2);
    chk("t5_id1", 32'(gnt_id), 1);
    done = 1'b1;
    req = 4'b1111;
    step();
    done = 1'b0;
    step();
    chk("t5_ptr", 32'(gnt), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_gnt", 32'(gnt), 0);
    chk("t6_vld", 32'(gnt_vld), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_to_id", 32'(timeout_id), 0);
    req = 4'b1000;
    #1;
    rst_n = 1'b1;
    step();
    chk("t6_gnt3", 32'(gnt), 32'h8);
    chk("t6_id3", 32'(gnt_id), 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shared_gate_arbiter.md
Name: shared_gate_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource (a wide combining gate stage, or any single-owner datapath) among N_REQ requesters.
- Issues a registered one-hot grant and holds it until the owner signals completion, drops its request, or exceeds a hold limit.
- Forces one idle cycle between owners so grant enables never overlap.
- Sits between the requesting logic and the shared cell's input-enable and mux selects.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..16.
- ID_W, 2, width of gnt_id; must equal clog2(N_REQ).
- MAX_HOLD, 16, maximum cycles a grant stays asserted before forced release; legal range 2..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester request level; bit i belongs to requester i.
- done  input  1  single-cycle pulse from the current owner ending its transaction.
- gnt  output  N_REQ  one-hot grant, registered.
- gnt_vld  output  1  high whenever any gnt bit is high.
- gnt_id  output  ID_W  binary index of the granted requester; 0 when gnt_vld is low.
- busy  output  1  high while in GRANT or GAP state.
- timeout  output  1  one-cycle pulse when a grant is force-released.
- timeout_id  output  ID_W  index of the last requester force-released; holds its value until the next timeout.

Behaviour:
- Clock and reset:
  - One clock: clk. Reset is asynchronous, active-low: rst_n.
  - While rst_n=0, all of the following are 0: gnt, gnt_vld, gnt_id, busy, timeout, timeout_id, hold counter, rr pointer. State is IDLE.
  - Reset asserted mid-grant clears gnt immediately (asynchronously), with no timeout pulse.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If req != 0 at edge t, the winner is chosen and gnt is high after edge t, i.e. visible in cycle t+1.
  - Next state GRANT. Hold counter loads 1. rr pointer <= (winner+1) mod N_REQ.
- Winner selection: the first set req bit searching ptr, ptr+1, ..., ptr+N_REQ-1, all mod N_REQ.
- GRANT (owner w):
  - Release when any of the following holds at an edge: done=1; req[w]=0; hold counter = MAX_HOLD.
  - Otherwise the hold counter increments by 1 per cycle. It saturates conceptually, and is never compared above MAX_HOLD.
  - On release: gnt cleared at that edge, next state GAP, hold counter cleared.
  - Timeout release only (counter = MAX_HOLD with done=0 and req[w]=1): timeout=1 for exactly the following cycle, and timeout_id <= w.
  - done=1 in the same cycle as counter = MAX_HOLD is a normal release; no timeout.
  - req from other requesters is ignored while in GRANT. No preemption.
- GAP:
  - Lasts exactly one cycle with gnt=0 and busy=1.
  - Next state IDLE-equivalent arbitration: if req != 0 at the GAP edge, go directly to GRANT with the new winner. Otherwise go to IDLE (busy=0).
  - Minimum spacing between two different grants is therefore one zero cycle.
- Back-to-back same requester is allowed if it is the only requester. Its grant reissues after the GAP cycle.
- done is ignored in IDLE and GAP.
- The rr pointer advances only when a grant is issued. Timeout does not alter pointer rules.
- gnt, gnt_vld and gnt_id are all flop outputs. gnt_id and gnt always agree on the same cycle.
- With N_REQ not a power of two, pointer wrap uses an explicit compare to N_REQ-1, not bit truncation.

Test Plan:
1. Reset, then req=4'b0001 at cycle 3 -> gnt=4'b0001, gnt_id=0, gnt_vld=1 from cycle 4. done pulse at cycle 7 -> gnt=0 at cycle 8 (GAP), busy=0 at cycle 9 with req dropped.
2. req=4'b1111 held and owner pulses done 2 cycles after each grant -> grant order 0,1,2,3,0. Exactly one zero-gnt cycle between grants. gnt is never multi-hot.
3. req=4'b0100 held, done never asserted, MAX_HOLD=16 -> gnt high for exactly 16 cycles, then timeout=1 for one cycle, timeout_id=2. Re-grant to requester 2 follows after one GAP cycle.
4. done and the hold limit coincide (done on the 16th grant cycle) -> normal release, timeout stays 0, timeout_id unchanged.
5. req=4'b1010, ptr=2, owner drops req[3] while granted with no done -> release next edge, GAP cycle, then grant to requester 1. ptr becomes 2 after that grant.
6. rst_n pulled low mid-GRANT (asynchronously, between edges) -> gnt=0 immediately. After release, with req=4'b1000, the first grant goes to requester 3 (pointer was reset to 0).
